// File: rtl/axis_packet_fifo_if.sv
// axis_if: AXI4-Stream beat bundle (data, strobes, last, valid/ready handshake)
interface axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: AXI4-Stream FIFO with cut-through or store-and-forward release
module axis_packet_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PKT_MODE   = 0
) (
    input  logic                axis_aclk,
    input  logic                axis_aresetn,
    axis_if.slave               s02_axis,
    axis_if.master              m02_axis,
    output logic [ADDR_WIDTH:0] occupancy,
    output logic                oversize
);
    localparam int EW = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

    logic [EW-1:0]         mem [2 ** ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   pkt_cnt;
    logic                  release_flag;
    logic [EW-1:0]         head;
    logic                  avail, push, pop, push_last, pop_last;

    assign head      = mem[rd_ptr];
    assign push      = s02_axis.tvalid && s02_axis.tready;
    assign pop       = avail && m02_axis.tready;
    assign push_last = push && s02_axis.tlast;
    assign pop_last  = pop && head[EW-1];

    // tready depends only on registered occupancy, so no input reaches it combinationally
    assign s02_axis.tready = occupancy < FULL;

    // Store-and-forward waits for a whole packet unless a full buffer forced a release
    assign avail = (PKT_MODE != 0) ? (pkt_cnt != '0 || (release_flag && occupancy != '0))
                                   : occupancy != '0;
    assign m02_axis.tvalid = avail;

    // Present the head entry while valid, zeros otherwise
    always_comb begin
        {m02_axis.tlast, m02_axis.tstrb, m02_axis.tdata} = avail ? head : '0;
    end

    // Beat storage; contents are never reset, pointers decide what is live
    always_ff @(posedge axis_aclk) begin
        if (push) mem[wr_ptr] <= {s02_axis.tlast, s02_axis.tstrb, s02_axis.tdata};
    end

    // Pointers, occupancy, complete-packet count and forced-release tracking
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            pkt_cnt      <= '0;
            release_flag <= 1'b0;
            oversize     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occupancy <= (push && !pop) ? occupancy + 1'b1 :
                         (!push && pop) ? occupancy - 1'b1 : occupancy;
            pkt_cnt   <= (push_last && !pop_last) ? pkt_cnt + 1'b1 :
                         (!push_last && pop_last) ? pkt_cnt - 1'b1 : pkt_cnt;
            if (PKT_MODE != 0 && occupancy == FULL && pkt_cnt == '0) begin
                release_flag <= 1'b1;
                oversize     <= 1'b1;
            end else if (pop_last) begin
                release_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: scoreboard bench for cut-through and store-and-forward instances
module tb_axis_packet_fifo;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_if #(.DATA_WIDTH(32)) ct_s (), ct_m (), sf_s (), sf_m ();
    logic [4:0] ct_occ, sf_occ;
    logic       ct_ovs, sf_ovs;

    axis_packet_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PKT_MODE(0)) dut_ct (
        .axis_aclk(aclk), .axis_aresetn(aresetn), .s02_axis(ct_s), .m02_axis(ct_m),
        .occupancy(ct_occ), .oversize(ct_ovs));
    axis_packet_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PKT_MODE(1)) dut_sf (
        .axis_aclk(aclk), .axis_aresetn(aresetn), .s02_axis(sf_s), .m02_axis(sf_m),
        .occupancy(sf_occ), .oversize(sf_ovs));

    logic [36:0] ct_q[$], sf_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output beats are compared against the scoreboard at the negedge before the pop edge
    always @(negedge aclk) begin
        if (aresetn) begin
            if (ct_m.tvalid && ct_m.tready) begin
                if (ct_q.size() == 0) check("ct_extra_beat", 64'(ct_q.size()), 64'd1);
                else check("ct_beat", {ct_m.tlast, ct_m.tstrb, ct_m.tdata}, ct_q.pop_front());
            end
            if (sf_m.tvalid && sf_m.tready) begin
                if (sf_q.size() == 0) check("sf_extra_beat", 64'(sf_q.size()), 64'd1);
                else check("sf_beat", {sf_m.tlast, sf_m.tstrb, sf_m.tdata}, sf_q.pop_front());
            end
        end
    end

    task automatic send(input bit sf, input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        if (sf) begin
            sf_s.tdata = d; sf_s.tstrb = s; sf_s.tlast = l; sf_s.tvalid = 1'b1;
        end else begin
            ct_s.tdata = d; ct_s.tstrb = s; ct_s.tlast = l; ct_s.tvalid = 1'b1;
        end
        @(negedge aclk);
        while (!(sf ? sf_s.tready : ct_s.tready) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) check("send_timeout", 64'(n), 64'd0);
        else if (sf) sf_q.push_back({l, s, d});
        else ct_q.push_back({l, s, d});
        @(posedge aclk);
        #1;
        if (sf) sf_s.tvalid = 1'b0;
        else ct_s.tvalid = 1'b0;
    endtask

    task automatic drain(input bit sf, input string tag);
        int n = 0;
        while (n < 200 && ((sf ? sf_q.size() : ct_q.size()) != 0 || (sf ? sf_occ : ct_occ) != 0)) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check({tag, "_occ"}, 64'(sf ? sf_occ : ct_occ), 64'd0);
        check({tag, "_pending"}, 64'(sf ? sf_q.size() : ct_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        ct_q.delete();
        sf_q.delete();
        aresetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ct_s.tvalid = 0; ct_s.tdata = 0; ct_s.tstrb = 0; ct_s.tlast = 0; ct_m.tready = 0;
        sf_s.tvalid = 0; sf_s.tdata = 0; sf_s.tstrb = 0; sf_s.tlast = 0; sf_m.tready = 0;
        do_reset();
        check("rst_ct_tready", ct_s.tready, 1);
        check("rst_ct_tvalid", ct_m.tvalid, 0);
        check("rst_ct_out", {ct_m.tlast, ct_m.tstrb, ct_m.tdata}, 0);
        check("rst_ct_occ", ct_occ, 0);
        check("rst_sf_tvalid", sf_m.tvalid, 0);
        check("rst_sf_ovs", sf_ovs, 0);

        // cut-through: four beats, valid right after each push
        ct_m.tready = 1;
        for (int i = 0; i < 4; i++) begin
            send(0, 32'hA0 + i, 4'hF, i == 3);
            check("ct_latency", ct_m.tvalid, 1);
        end
        drain(0, "ct_drain");

        // fill to DEPTH, then a single pop frees a slot
        ct_m.tready = 0;
        for (int i = 0; i < 16; i++) send(0, 32'hB0 + i, 4'(i), i == 15);
        check("full_tready", ct_s.tready, 0);
        check("full_occ", ct_occ, 16);
        check("full_head", ct_m.tdata, 32'hB0);
        check("ct_ovs_zero", ct_ovs, 0);
        ct_m.tready = 1;
        @(posedge aclk);
        #1;
        ct_m.tready = 0;
        check("pop_tready", ct_s.tready, 1);
        check("pop_occ", ct_occ, 15);
        ct_m.tready = 1;
        drain(0, "full_drain");

        // concurrent push and pop at occupancy 8 with pointer wrap
        ct_m.tready = 0;
        for (int i = 0; i < 8; i++) send(0, 32'h100 + i, 4'hF, i % 4 == 3);
        ct_m.tready = 1;
        for (int i = 0; i < 20; i++) begin
            send(0, 32'h200 + i, 4'(i * 3), i % 5 == 4);
            check("simul_occ", ct_occ, 8);
        end
        drain(0, "simul_drain");

        // store-and-forward holds until tlast arrives
        sf_m.tready = 1;
        for (int i = 0; i < 5; i++) begin
            send(1, 32'hC0 + i, 4'hF, 0);
            check("sf_hold", sf_m.tvalid, 0);
        end
        check("sf_hold_data", sf_m.tdata, 0);
        send(1, 32'hC5, 4'h3, 1);
        check("sf_release", sf_m.tvalid, 1);
        drain(1, "sf_drain");

        // oversize: full buffer with no complete packet forces release
        sf_m.tready = 0;
        for (int i = 0; i < 16; i++) send(1, 32'hD0 + i, 4'(i), 0);
        check("ovs_occ", sf_occ, 16);
        check("ovs_before", sf_ovs, 0);
        check("ovs_valid_before", sf_m.tvalid, 0);
        @(posedge aclk);
        #1;
        check("ovs_set", sf_ovs, 1);
        check("ovs_valid", sf_m.tvalid, 1);
        sf_m.tready = 1;
        send(1, 32'hE0, 4'hF, 0);
        send(1, 32'hE1, 4'hF, 1);
        drain(1, "ovs_drain");
        send(1, 32'hF0, 4'hF, 0);
        repeat (3) @(posedge aclk);
        #1;
        check("release_cleared", sf_m.tvalid, 0);
        check("release_occ", sf_occ, 1);
        check("ovs_sticky", sf_ovs, 1);
        send(1, 32'hF1, 4'hF, 1);
        drain(1, "post_ovs_drain");

        // reset mid-packet discards the partial packet
        ct_m.tready = 0;
        for (int i = 0; i < 3; i++) send(0, 32'h300 + i, 4'hF, 0);
        do_reset();
        check("mid_rst_occ", ct_occ, 0);
        check("mid_rst_tvalid", ct_m.tvalid, 0);
        check("mid_rst_data", ct_m.tdata, 0);
        check("mid_rst_tready", ct_s.tready, 1);
        check("mid_rst_ovs", sf_ovs, 0);
        ct_m.tready = 1;
        send(0, 32'h400, 4'h5, 0);
        send(0, 32'h401, 4'hA, 1);
        drain(0, "mid_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the stream data width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the buffer depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter PKT_MODE, default 0, SHALL select the output mode: 0 = cut-through, 1 = store-and-forward.
REQ-004 axis_aclk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 axis_aresetn  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 s02_axis_tdata  in  DATA_WIDTH  SHALL carry write beat data.
REQ-007 s02_axis_tstrb  in  DATA_WIDTH/8  SHALL carry write beat byte strobes.
REQ-008 s02_axis_tvalid  in  1  SHALL indicate a valid write beat.
REQ-009 s02_axis_tlast  in  1  SHALL mark the last beat of a packet.
REQ-010 s02_axis_tready  out  1  SHALL indicate the block accepts a write beat.
REQ-011 m02_axis_tdata  out  DATA_WIDTH  SHALL carry read beat data.
REQ-012 m02_axis_tstrb  out  DATA_WIDTH/8  SHALL carry read beat strobes.
REQ-013 m02_axis_tvalid  out  1  SHALL indicate a valid read beat.
REQ-014 m02_axis_tlast  out  1  SHALL mark the last read beat of a packet.
REQ-015 m02_axis_tready  in  1  SHALL indicate the downstream accepts a read beat.
REQ-016 occupancy  out  ADDR_WIDTH+1  SHALL report stored entries, 0..DEPTH.
REQ-017 oversize  out  1  SHALL flag a forced release (REQ-029), sticky until reset.

Function
REQ-018 Write handshake: a beat SHALL be stored iff s02_axis_tvalid && s02_axis_tready at a clock edge; tdata, tstrb and tlast SHALL be stored together in one entry.
REQ-019 s02_axis_tready SHALL be 1 iff occupancy < DEPTH, decoded from registered state only (no combinational path from any input).
REQ-020 Read handshake: an entry SHALL be popped iff m02_axis_tvalid && m02_axis_tready at a clock edge.
REQ-021 m02_axis_tdata/tstrb/tlast SHALL present the head entry whenever m02_axis_tvalid = 1, and SHALL drive all-zero when m02_axis_tvalid = 0 (never high-impedance).
REQ-022 Once m02_axis_tvalid = 1, it and the presented data SHALL hold stable until popped.
REQ-023 Write and read pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
REQ-024 Occupancy SHALL update as follows:
- +1 on push only.
- -1 on pop only.
- Unchanged on simultaneous push and pop.
REQ-025 Simultaneous push and pop SHALL be legal at any occupancy where both handshakes complete, including 1..DEPTH-1.
REQ-026 Latency SHALL be 1 cycle in cut-through mode: a beat pushed at edge N SHALL make m02_axis_tvalid = 1 after edge N.
REQ-027 PKT_MODE=0: m02_axis_tvalid SHALL be 1 iff occupancy > 0.
REQ-028 PKT_MODE=1: a complete-packet counter (ADDR_WIDTH+1 bits) SHALL be maintained:
- +1 on a push with tlast = 1.
- -1 on a pop with tlast = 1.
- Unchanged when both occur together.
- m02_axis_tvalid SHALL be 1 iff the counter > 0, or the release flag (REQ-029) is set and occupancy > 0.
REQ-029 PKT_MODE=1 forced release: when occupancy = DEPTH and the packet counter = 0, then at the next edge:
- The release flag SHALL set.
- oversize SHALL set.
- The release flag SHALL clear on the pop of a beat with tlast = 1.
REQ-030 PKT_MODE=0: oversize SHALL remain 0.
REQ-031 Strobe values SHALL pass through unmodified; all-zero strobes SHALL be stored and forwarded like any beat.

Reset
REQ-032 While axis_aresetn = 0 at an edge, the following SHALL clear to 0: pointers, occupancy, packet counter, release flag and oversize.
REQ-033 After a reset edge, outputs SHALL be:
- s02_axis_tready = 1.
- m02_axis_tvalid = 0.
- m02_axis_tdata/tstrb/tlast = 0.
REQ-034 Reset mid-packet SHALL discard all stored beats; a partial packet SHALL NOT be emitted after reset.
REQ-035 Memory contents need not reset.

Verification
REQ-036 The bench SHALL cover these scenarios (DEPTH = 16, DATA_WIDTH = 32):
- Cut-through: push 0xA0..0xA3 with tlast on the 4th beat, m02_axis_tready = 1 -> same four words out in order, tvalid one cycle after each push, tlast only on 0xA3.
- Full: m02_axis_tready = 0, push 16 beats -> s02_axis_tready = 0 after the 16th and occupancy = 16; one pop -> tready = 1 on the next cycle.
- Simultaneous push and pop at occupancy 8 for 20 cycles -> occupancy stays 8, pointers wrap, data order preserved.
- Store-and-forward: push 5 beats without tlast -> m02_axis_tvalid stays 0; push a 6th beat with tlast -> tvalid = 1 the next cycle; 6 beats out.
- Oversize (PKT_MODE=1): push 17+ beats without tlast -> oversize = 1 at occupancy 16, beats drain, release clears after the tlast beat is popped.
- Reset mid-packet: assert axis_aresetn = 0 after 3 of 6 beats -> occupancy = 0 and m02_axis_tvalid = 0; a following 2-beat packet emerges intact.
